act_unit_pipe: RTL and testbench

- Parametrised, multi-lane activation stage that replaces the single-lane registered ReLU after the PE array, ahead of pooling.
- Applies one of four activation modes per beat across NUM_CH signed lanes.
- 2-stage pipeline with valid/ready backpressure carries a per-beat PE state tag unchanged.
- Exposes saturating counters for zeroed and clipped elements, used for sparsity/overflow profiling.

---
 rtl/act_unit_pipe_if.sv | 25 ++
 rtl/act_unit_pipe.sv | 100 ++++++++++
 tb/tb_act_unit_pipe.sv | 253 +++++++++++++++++++++++++
 3 files changed

// File: rtl/act_unit_pipe_if.sv
// act_unit_pipe_if: beat stream into and out of the activation stage
interface act_unit_pipe_if #(
  parameter int DATA_WID = 16,
  parameter int NUM_CH = 4,
  parameter int TAG_WID = 2
);
  logic in_valid;
  logic in_ready;
  logic [NUM_CH*DATA_WID-1:0] in_data;
  logic [TAG_WID-1:0] in_tag;
  logic [1:0] in_mode;
  logic [DATA_WID-1:0] clip_max;
  logic out_valid;
  logic out_ready;
  logic [NUM_CH*DATA_WID-1:0] out_data;
  logic [TAG_WID-1:0] out_tag;
  modport master (
    output in_valid, in_data, in_tag, in_mode, clip_max, out_ready,
    input in_ready, out_valid, out_data, out_tag
  );
  modport slave (
    input in_valid, in_data, in_tag, in_mode, clip_max, out_ready,
    output in_ready, out_valid, out_data, out_tag
  );
endinterface

// File: rtl/act_unit_pipe.sv
// act_unit_pipe: 2-stage multi-lane activation (bypass/ReLU/leaky/clipped) with zero/clip profiling counters
module act_unit_pipe #(
  parameter int DATA_WID = 16,
  parameter int NUM_CH = 4,
  parameter int TAG_WID = 2,
  parameter int LEAK_SHIFT = 3,
  parameter int CNT_WID = 16
) (
  input  logic clk,
  input  logic reset,
  act_unit_pipe_if.slave bus,
  input  logic stat_clr,
  output logic [CNT_WID-1:0] zero_cnt,
  output logic [CNT_WID-1:0] clip_cnt
);
  localparam int W = NUM_CH * DATA_WID;
  localparam int PW = $clog2(NUM_CH + 1);
  logic s1_valid, s2_valid, s1_load, s2_load, s2_adv;
  logic [W-1:0] s1_data, s2_data, act;
  logic [TAG_WID-1:0] s1_tag, s2_tag;
  logic [1:0] s1_mode;
  logic signed [DATA_WID-1:0] s1_clip;
  logic [NUM_CH-1:0] zero_lane, clip_lane;
  logic [PW-1:0] zero_pop, clip_pop;
  logic [CNT_WID+PW-1:0] zero_sum, clip_sum;
  assign s2_adv = ~s2_valid | bus.out_ready;
  assign bus.in_ready = ~s1_valid | s2_adv;
  assign s1_load = bus.in_valid & bus.in_ready;
  assign s2_load = s1_valid & s2_adv;
  assign bus.out_valid = s2_valid;
  assign bus.out_data = s2_data;
  assign bus.out_tag = s2_tag;
  for (genvar i = 0; i < NUM_CH; i++) begin : g_lane
    logic signed [DATA_WID-1:0] x, leak;
    assign x = s1_data[i*DATA_WID +: DATA_WID];
    assign leak = x >>> LEAK_SHIFT;
    assign zero_lane[i] = x[DATA_WID-1] & s1_mode[0];
    assign clip_lane[i] = ~x[DATA_WID-1] & (s1_mode == 2'd3) & (x > s1_clip);
    assign act[i*DATA_WID +: DATA_WID] = s1_mode == 2'd0 ? x :
                                         zero_lane[i] ? '0 :
                                         x[DATA_WID-1] ? leak :
                                         clip_lane[i] ? s1_clip : x;
  end
  // Count zeroed and clipped lanes of the beat sitting in stage 1
  always_comb begin
    zero_pop = '0;
    clip_pop = '0;
    for (int k = 0; k < NUM_CH; k++) begin
      zero_pop = zero_pop + PW'(zero_lane[k]);
      clip_pop = clip_pop + PW'(clip_lane[k]);
    end
  end
  assign zero_sum = {{PW{1'b0}}, zero_cnt} + {{CNT_WID{1'b0}}, zero_pop};
  assign clip_sum = {{PW{1'b0}}, clip_cnt} + {{CNT_WID{1'b0}}, clip_pop};
  // Stage 1: capture the raw beat together with its own mode and clip bound
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1_valid <= 1'b0;
      s1_data <= '0;
      s1_tag <= '0;
      s1_mode <= '0;
      s1_clip <= '0;
    end else if (bus.in_ready) begin
      s1_valid <= bus.in_valid;
      if (s1_load) begin
        s1_data <= bus.in_data;
        s1_tag <= bus.in_tag;
        s1_mode <= bus.in_mode;
        s1_clip <= bus.clip_max;
      end
    end
  end
  // Stage 2: register activated lanes; holds while downstream stalls
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s2_valid <= 1'b0;
      s2_data <= '0;
      s2_tag <= '0;
    end else if (s2_adv) begin
      s2_valid <= s1_valid;
      if (s2_load) begin
        s2_data <= act;
        s2_tag <= s1_tag;
      end
    end
  end
  // Saturating statistics; clear wins over a same-cycle load
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      zero_cnt <= '0;
      clip_cnt <= '0;
    end else if (stat_clr) begin
      zero_cnt <= '0;
      clip_cnt <= '0;
    end else if (s2_load) begin
      zero_cnt <= |zero_sum[CNT_WID+PW-1:CNT_WID] ? '1 : zero_sum[CNT_WID-1:0];
      clip_cnt <= |clip_sum[CNT_WID+PW-1:CNT_WID] ? '1 : clip_sum[CNT_WID-1:0];
    end
  end
endmodule

// File: tb/tb_act_unit_pipe.sv
// tb_act_unit_pipe: table vectors plus scoreboarded streaming, saturation and reset sequences
module tb_act_unit_pipe;
  localparam int DW = 16;
  localparam int NC = 4;
  localparam int TW = 2;
  localparam int LS = 3;
  localparam int CW = 4;
  localparam int SAT = (1 << CW) - 1;
  typedef struct packed {
    logic [TW-1:0] tag;
    logic [NC*DW-1:0] data;
  } beat_t;
  typedef struct {
    logic [TW-1:0] tag;
    logic [1:0] mode;
    logic [DW-1:0] clip;
    logic [NC*DW-1:0] din;
    logic [NC*DW-1:0] dout;
    int ez;
    int ec;
  } vec_t;
  logic clk = 1'b0;
  logic reset = 1'b0;
  logic stat_clr = 1'b0;
  logic [CW-1:0] zero_cnt, clip_cnt;
  int n_cmp = 0;
  int n_fail = 0;
  int n_out = 0;
  beat_t q[$];
  beat_t prev;
  logic stall_prev = 1'b0;
  vec_t vt[7];
  act_unit_pipe_if #(.DATA_WID(DW), .NUM_CH(NC), .TAG_WID(TW)) bus ();
  act_unit_pipe #(.DATA_WID(DW), .NUM_CH(NC), .TAG_WID(TW), .LEAK_SHIFT(LS), .CNT_WID(CW)) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus.slave),
    .stat_clr(stat_clr),
    .zero_cnt(zero_cnt),
    .clip_cnt(clip_cnt)
  );
  always #5 clk = ~clk;
  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask
  function automatic logic [NC*DW-1:0] pk(input int a, input int b, input int c, input int d);
    return {DW'(d), DW'(c), DW'(b), DW'(a)};
  endfunction
  function automatic logic [NC*DW-1:0] model(input logic [NC*DW-1:0] d, input logic [1:0] m,
                                            input logic [DW-1:0] c, output int zc, output int cc);
    logic [NC*DW-1:0] r;
    int k;
    int v;
    int cl;
    int o;
    k = 1 << LS;
    cl = int'($signed(c));
    zc = 0;
    cc = 0;
    r = '0;
    for (int i = 0; i < NC; i++) begin
      v = int'($signed(d[i*DW +: DW]));
      if (m == 2'd0) o = v;
      else if (v < 0) o = (m == 2'd2) ? -((-v + k - 1) / k) : 0;
      else o = (m == 2'd3 && v > cl) ? cl : v;
      if (v < 0 && (m == 2'd1 || m == 2'd3)) zc++;
      if (v >= 0 && m == 2'd3 && v > cl) cc++;
      r[i*DW +: DW] = DW'(o);
    end
    return r;
  endfunction
  task automatic send(input logic [NC*DW-1:0] d, input logic [1:0] m, input logic [DW-1:0] c,
                      input logic [TW-1:0] t, input logic [NC*DW-1:0] e);
    bit ok;
    ok = 1'b0;
    bus.in_valid = 1'b1;
    bus.in_data = d;
    bus.in_mode = m;
    bus.clip_max = c;
    bus.in_tag = t;
    for (int k = 0; k < 200 && !ok; k++) begin
      @(negedge clk);
      ok = bus.in_ready;
    end
    if (ok) q.push_back('{t, e});
    else check("in_ready_timeout", 64'd0, 64'd1);
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask
  task automatic clr_stats();
    stat_clr = 1'b1;
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
  endtask
  task automatic mon_step();
    beat_t e;
    if (stall_prev) begin
      check("hold_data", bus.out_data, prev.data);
      check("hold_tag", 64'(bus.out_tag), 64'(prev.tag));
    end
    if (!bus.in_ready) check("in_ready_drop", 64'({bus.out_valid, bus.out_ready}), 64'd2);
    if (bus.out_valid && bus.out_ready) begin
      if (q.size() == 0) check("unexpected_out", 64'd1, 64'd0);
      else begin
        e = q.pop_front();
        check("out_data", bus.out_data, e.data);
        check("out_tag", 64'(bus.out_tag), 64'(e.tag));
        n_out++;
      end
    end
  endtask
  always @(negedge clk) begin
    if (!reset) begin
      mon_step();
      stall_prev <= bus.out_valid && !bus.out_ready;
      prev <= '{bus.out_tag, bus.out_data};
    end else stall_prev <= 1'b0;
  end
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end
  initial begin
    int zs, cs, zc, cc, base;
    bit done;
    logic [NC*DW-1:0] d, e;
    logic [1:0] m;
    logic [DW-1:0] c;
    vt[0] = '{2'd1, 2'd1, 16'd0, pk(-5, 0, 7, -32768), pk(0, 0, 7, 0), 2, 0};
    vt[1] = '{2'd2, 2'd2, 16'd0, pk(-1, -9, -32768, 100), pk(-1, -2, -4096, 100), 0, 0};
    vt[2] = '{2'd3, 2'd3, 16'd50, pk(60, 50, -3, 10), pk(50, 50, 0, 10), 1, 1};
    vt[3] = '{2'd0, 2'd0, 16'd7, pk(-32768, -1, 32767, 5), pk(-32768, -1, 32767, 5), 0, 0};
    vt[4] = '{2'd1, 2'd3, 16'd0, pk(-32768, 32767, 0, 1), pk(0, 0, 0, 0), 1, 2};
    vt[5] = '{2'd2, 2'd2, 16'd9, pk(-8, -7, 8, 0), pk(-1, -1, 8, 0), 0, 0};
    vt[6] = '{2'd3, 2'd3, 16'd32767, pk(32767, -1, -32768, 1000), pk(32767, 0, 0, 1000), 2, 0};
    bus.in_valid = 1'b0;
    bus.in_data = '0;
    bus.in_tag = '0;
    bus.in_mode = '0;
    bus.clip_max = '0;
    bus.out_ready = 1'b1;
    #1 reset = 1'b1;
    #2;
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_out_data", bus.out_data, 64'd0);
    check("rst_out_tag", 64'(bus.out_tag), 64'd0);
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_zero_cnt", 64'(zero_cnt), 64'd0);
    check("rst_clip_cnt", 64'(clip_cnt), 64'd0);
    @(posedge clk);
    @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    #1;
    foreach (vt[v]) begin
      clr_stats();
      send(vt[v].din, vt[v].mode, vt[v].clip, vt[v].tag, vt[v].dout);
      check("lat1_valid", 64'(bus.out_valid), 64'd0);
      @(posedge clk);
      #1;
      check("lat2_valid", 64'(bus.out_valid), 64'd1);
      check("vec_zero_cnt", 64'(zero_cnt), 64'(vt[v].ez));
      check("vec_clip_cnt", 64'(clip_cnt), 64'(vt[v].ec));
      @(posedge clk);
      #1;
    end
    clr_stats();
    zs = 0;
    cs = 0;
    base = n_out;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < 10; i++) begin
          d = {$urandom(), $urandom()};
          m = 2'($urandom_range(0, 3));
          c = DW'($urandom_range(0, 32767));
          e = model(d, m, c, zc, cc);
          zs += zc;
          cs += cc;
          send(d, m, c, TW'(i), e);
        end
        for (int k = 0; k < 100 && n_out - base < 10; k++) @(posedge clk);
        done = 1'b1;
      end
      begin
        int cyc;
        cyc = 0;
        while (!done) begin
          @(posedge clk);
          #1;
          bus.out_ready = (cyc % 4 == 0) || (cyc % 4 == 3);
          cyc++;
        end
      end
    join
    bus.out_ready = 1'b1;
    check("stream_count", 64'(n_out - base), 64'd10);
    @(posedge clk);
    #1;
    check("stream_zero_cnt", 64'(zero_cnt), 64'(zs > SAT ? SAT : zs));
    check("stream_clip_cnt", 64'(clip_cnt), 64'(cs > SAT ? SAT : cs));
    clr_stats();
    for (int i = 0; i < 5; i++) send(pk(-1, -100, -32768, -7), 2'd1, 16'd0, 2'd0, '0);
    repeat (3) @(posedge clk);
    #1;
    check("sat_zero_cnt", 64'(zero_cnt), 64'(SAT));
    send(pk(-2, -2, -2, -2), 2'd1, 16'd0, 2'd1, '0);
    stat_clr = 1'b1;
    @(posedge clk);
    #1;
    stat_clr = 1'b0;
    check("clr_vs_load", 64'(zero_cnt), 64'd0);
    for (int i = 0; i < 5; i++) send(pk(5, 6, 7, 8), 2'd3, 16'd4, 2'd2, pk(4, 4, 4, 4));
    repeat (3) @(posedge clk);
    #1;
    check("sat_clip_cnt", 64'(clip_cnt), 64'(SAT));
    clr_stats();
    send(pk(-3, -3, -3, -3), 2'd1, 16'd0, 2'd1, '0);
    send(pk(9, 9, 9, 9), 2'd0, 16'd0, 2'd2, pk(9, 9, 9, 9));
    check("pre_reset_valid", 64'(bus.out_valid), 64'd1);
    check("pre_reset_zero", 64'(zero_cnt), 64'd4);
    #1 reset = 1'b1;
    #1;
    check("async_out_valid", 64'(bus.out_valid), 64'd0);
    check("async_out_data", bus.out_data, 64'd0);
    check("async_in_ready", 64'(bus.in_ready), 64'd1);
    q.delete();
    @(posedge clk);
    #3 reset = 1'b0;
    @(posedge clk);
    #1;
    send(pk(1, -1, 2, -2), 2'd0, 16'd0, 2'd3, pk(1, -1, 2, -2));
    check("post_lat1_valid", 64'(bus.out_valid), 64'd0);
    @(posedge clk);
    #1;
    check("post_lat2_valid", 64'(bus.out_valid), 64'd1);
    check("post_zero_cnt", 64'(zero_cnt), 64'd0);
    check("post_clip_cnt", 64'(clip_cnt), 64'd0);
    repeat (2) @(posedge clk);
    #1;
    check("queue_empty", 64'(q.size()), 64'd0);
    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end
endmodule
